// File: rtl/placar_hex.sv
// Score/status display: buffers kill pulses, drains them into a saturating 4-digit BCD score and drives HEX5..HEX0.
// Latency: kill sampled at edge t+1 -> pending at t+1, score at t+2, HEX segments at t+3 (all outputs registered).
// Backpressure: none; kills beyond 15 pending are dropped. Optional high-score register under macro PLACAR_RECORDE_EN.
module placar_hex #(
  parameter int PONTOS    = 1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       perdeu,
  input  logic [1:0] vidas,
  input  logic [4:0] inimigo_morto,
  input  logic       nova_partida,
  input  logic       mostra_recorde,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [3:0]      pend_q, pend_d;
  logic [15:0]     score_q, score_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic [5:0][6:0] hex_q, hex_d;

  logic [2:0]  kills;
  logic        dec;
  logic [4:0]  pend_sum;
  logic [15:0] score_inc;
  logic [4:0]  bcd_t;
  logic [4:0]  bcd_add;
  logic [15:0] disp_val;
  logic        show_rec;

  // Kill intake and drain request; paused or lost games accept no new kills.
  always_comb begin
    kills = 3'(inimigo_morto[0]) + 3'(inimigo_morto[1]) + 3'(inimigo_morto[2])
          + 3'(inimigo_morto[3]) + 3'(inimigo_morto[4]);
    if (pausa || perdeu) kills = 3'd0;
    dec      = (pend_q != 4'd0) && !pausa;
    pend_sum = {1'b0, pend_q} + {2'b00, kills} - {4'b0000, dec};
  end

  // BCD add of PONTOS into digit 0 with ripple carry; overflow past 9999 clamps.
  always_comb begin
    score_inc = '0;
    bcd_t     = '0;
    bcd_add   = 5'(PONTOS);
    for (int i = 0; i < 4; i++) begin
      bcd_t = {1'b0, score_q[4*i +: 4]} + bcd_add;
      if (bcd_t > 5'd9) begin
        score_inc[4*i +: 4] = 4'(bcd_t - 5'd10);
        bcd_add = 5'd1;
      end else begin
        score_inc[4*i +: 4] = bcd_t[3:0];
        bcd_add = 5'd0;
      end
    end
    if (bcd_add != 5'd0) score_inc = 16'h9999;
  end

  // Next-state for pending count, score and blink timer; a new game overrides kills and drain.
  always_comb begin
    pend_d  = (pend_sum > 5'd15) ? 4'd15 : pend_sum[3:0];
    score_d = dec ? score_inc : score_q;
    if (nova_partida) begin
      pend_d  = 4'd0;
      score_d = 16'h0000;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_on_d  = blink_on_q;
    end
  end

`ifdef PLACAR_RECORDE_EN
  logic [15:0] rec_q, rec_d;

  // High score captures the pre-clear score when a new game starts; BCD orders like binary.
  always_comb begin
    rec_d = rec_q;
    if (nova_partida && (score_q > rec_q)) rec_d = score_q;
  end

  // High-score register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) rec_q <= 16'h0000;
    else        rec_q <= rec_d;
  end

  assign show_rec = mostra_recorde;
  assign disp_val = mostra_recorde ? rec_q : score_q;
`else
  logic unused_mostra;
  assign unused_mostra = mostra_recorde;
  assign show_rec      = 1'b0;
  assign disp_val      = score_q;
`endif

  // Segment decode for all six displays; HEX5 shows high-score tag, then lost (blinking F), then paused.
  always_comb begin
    hex_d[0] = seg7(disp_val[3:0]);
    hex_d[1] = seg7(disp_val[7:4]);
    hex_d[2] = seg7(disp_val[11:8]);
    hex_d[3] = seg7(disp_val[15:12]);
    hex_d[4] = seg7({2'b00, vidas});
    hex_d[5] = SEG_BLANK;
    if (show_rec)    hex_d[5] = SEG_R;
    else if (perdeu) hex_d[5] = blink_on_q ? SEG_F : SEG_BLANK;
    else if (pausa)  hex_d[5] = SEG_P;
  end

  // Game state registers.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      pend_q      <= 4'd0;
      score_q     <= 16'h0000;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      pend_q      <= pend_d;
      score_q     <= score_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Registered segment outputs, blank while in reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) hex_q <= {6{SEG_BLANK}};
    else        hex_q <= hex_d;
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_placar_hex.sv
// Bench for placar_hex: directed scenarios plus random traffic against a decimal reference model.
// Expected HEX vector per cycle is queued at each rising edge and compared at the following falling edge.
// Works in both builds; the model follows PLACAR_RECORDE_EN the same way as the design.
module tb_placar_hex;
  localparam int P  = 7;
  localparam int BD = 4;
`ifdef PLACAR_RECORDE_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic       CLOCK_50;
  logic       reset, pausa, perdeu, nova_partida, mostra_recorde;
  logic [1:0] vidas;
  logic [4:0] inimigo_morto;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  placar_hex #(.PONTOS(P), .BLINK_DIV(BD)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .perdeu(perdeu),
    .vidas(vidas), .inimigo_morto(inimigo_morto), .nova_partida(nova_partida),
    .mostra_recorde(mostra_recorde),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [41:0] expq[$];

  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state, plain integers.
  int m_score = 0, m_pend = 0, m_bcnt = 0, m_rec = 0;
  bit m_on = 1'b1;

  function automatic logic [27:0] digits(input int v);
    digits = {SEG[(v / 1000) % 10], SEG[(v / 100) % 10], SEG[(v / 10) % 10], SEG[v % 10]};
  endfunction

  always @(posedge CLOCK_50) begin
    logic [41:0] e;
    logic [6:0]  h5;
    int k;
    bit d;
    if (!reset) begin
      e = {6{7'h7F}};
      m_score = 0; m_pend = 0; m_bcnt = 0; m_on = 1'b1; m_rec = 0;
    end else begin
      if (mostra_recorde && REC) h5 = 7'h2F;
      else if (perdeu)           h5 = m_on ? 7'h0E : 7'h7F;
      else if (pausa)            h5 = 7'h0C;
      else                       h5 = 7'h7F;
      e = {h5, SEG[vidas], digits((mostra_recorde && REC) ? m_rec : m_score)};
      k = (pausa || perdeu) ? 0 : $countones(inimigo_morto);
      d = (m_pend > 0) && !pausa;
      if (nova_partida) begin
        if (REC && m_score > m_rec) m_rec = m_score;
        m_score = 0;
        m_pend  = 0;
      end else begin
        if (d) m_score = (m_score + P > 9999) ? 9999 : m_score + P;
        m_pend = m_pend + k - int'(d);
        if (m_pend > 15) m_pend = 15;
      end
      if (m_bcnt == BD - 1) begin m_bcnt = 0; m_on = !m_on; end
      else m_bcnt = m_bcnt + 1;
    end
    expq.push_back(e);
  end

  always @(negedge CLOCK_50) begin
    logic [41:0] e, a;
    cyc = cyc + 1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL hex_cyc%0d got HEX5..0=%h_%h_%h_%h_%h_%h want %h_%h_%h_%h_%h_%h", cyc,
                 a[41:35], a[34:28], a[27:21], a[20:14], a[13:7], a[6:0],
                 e[41:35], e[34:28], e[27:21], e[20:14], e[13:7], e[6:0]);
      end
    end
  end

  task automatic step(input logic [4:0] km, input logic np);
    @(negedge CLOCK_50);
    inimigo_morto = km;
    nova_partida  = np;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; pausa = 1'b0; perdeu = 1'b0; vidas = 2'd3;
    inimigo_morto = 5'd0; nova_partida = 1'b0; mostra_recorde = 1'b0;
    idle(3);
    reset = 1'b1;
    // single kill latency
    step(5'b00001, 1'b0); idle(6);
    // five simultaneous kills drain one per cycle
    step(5'b11111, 1'b0); idle(8);
    // kill coinciding with new game is discarded
    step(5'b00001, 1'b1); idle(4);
    // pending freeze under pause, kills ignored
    step(5'b00111, 1'b0);
    pausa = 1'b1;
    for (int i = 0; i < 3; i++) begin step(5'b00001, 1'b0); idle(1); end
    idle(4);
    pausa = 1'b0; idle(5);
    // lost: blinking F, kills ignored but pending drains
    step(5'b00011, 1'b0);
    perdeu = 1'b1;
    for (int i = 0; i < 6; i++) begin step(5'b10101, 1'b0); idle(2); end
    idle(10);
    perdeu = 1'b0; vidas = 2'd1;
    // twelve kills, new game, then show high score
    step(5'b11111, 1'b0); step(5'b11111, 1'b0); step(5'b00011, 1'b0);
    idle(16);
    step(5'd0, 1'b1);
    mostra_recorde = 1'b1; idle(4);
    mostra_recorde = 1'b0; idle(4);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      @(negedge CLOCK_50);
      inimigo_morto  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      nova_partida   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) pausa = ~pausa;
      if ($urandom_range(0, 23) == 0) perdeu = ~perdeu;
      if ($urandom_range(0, 7) == 0)  vidas = 2'($urandom);
      if ($urandom_range(0, 7) == 0)  mostra_recorde = ~mostra_recorde;
      reset = ($urandom_range(0, 199) != 0);
    end
    reset = 1'b1; pausa = 1'b0; perdeu = 1'b0; mostra_recorde = 1'b0;
    // saturation at 9999
    for (int i = 0; i < 1500; i++) step(5'b11111, 1'b0);
    idle(20);
    step(5'b00001, 1'b0); idle(6);
    pausa = 1'b1; idle(3); pausa = 1'b0;
    step(5'd0, 1'b1);
    mostra_recorde = 1'b1; idle(4);
    mostra_recorde = 1'b0; idle(4);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    #1;
    checks = checks + 1;
    if (expq.size() > 1) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got %0d pending entries want at most 1", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
